// File: rtl/instr_decode_queue.sv
// -----------------------------------------------------------------------------
// instr_decode_queue
//   RV32I decode stage. Fetched instructions enter a DEPTH-entry FIFO. The head
//   entry is decoded combinationally and captured into a registered micro-op
//   output, which is issued to the ROB/RS with a valid/ready handshake. Total
//   buffering is DEPTH+1: the FIFO plus the output register.
//
// Optional build macro:
//   DECODE_MULDIV_EN  - decode RV32M (OP with funct7==0000001) as outMulDiv=1.
//                       When undefined, outMulDiv is always 0 and that encoding
//                       is reported as illegal. The port list is the same in
//                       both builds.
//
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   flush            synchronous clear of the FIFO and the output register
//   inValid/inReady  fetch handshake; inInstr/inPc carry the instruction
//   outValid/outReady issue handshake for the decoded op
//   outOpType..outMulDiv  decoded micro-op fields (registered)
//   count            FIFO occupancy 0..DEPTH (output register not included)
// -----------------------------------------------------------------------------
module instr_decode_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [31:0]      inInstr,
    input  logic [31:0]      inPc,
    output logic             outValid,
    input  logic             outReady,
    output logic [6:0]       outOpType,
    output logic [2:0]       outSubType,
    output logic             outFlag,
    output logic [31:0]      outImm,
    output logic [31:0]      outPc,
    output logic [4:0]       outRs1,
    output logic [4:0]       outRs2,
    output logic [4:0]       outRd,
    output logic             outUseRs1,
    output logic             outUseRs2,
    output logic             outWritesRd,
    output logic             outIllegal,
    output logic             outMulDiv,
    output logic [PTR_W:0]   count
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // FIFO storage: {pc, instr}
    logic [63:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   cnt_nxt_s;
    logic             in_ready_r;

    logic             push_s;
    logic             pop_s;
    logic [31:0]      head_instr_s;
    logic [31:0]      head_pc_s;

    // Decoder results for the FIFO head
    logic [2:0]       dec_sub_s;
    logic             dec_flag_s;
    logic [31:0]      dec_imm_s;
    logic [4:0]       dec_rs1_s;
    logic [4:0]       dec_rs2_s;
    logic [4:0]       dec_rd_s;
    logic             dec_use_rs1_s;
    logic             dec_use_rs2_s;
    logic             dec_use_rd_s;
    logic             dec_illegal_s;
    logic             dec_muldiv_s;

    // Registered micro-op
    logic             out_valid_r;
    logic [6:0]       out_op_r;
    logic [2:0]       out_sub_r;
    logic             out_flag_r;
    logic [31:0]      out_imm_r;
    logic [31:0]      out_pc_r;
    logic [4:0]       out_rs1_r;
    logic [4:0]       out_rs2_r;
    logic [4:0]       out_rd_r;
    logic             out_use_rs1_r;
    logic             out_use_rs2_r;
    logic             out_writes_rd_r;
    logic             out_illegal_r;
    logic             out_muldiv_r;

    // in_ready_r always equals (count_r < DEPTH); a pop never frees space for a same-cycle push.
    assign push_s       = inValid && in_ready_r;
    assign pop_s        = (!out_valid_r || outReady) && (count_r != {(PTR_W+1){1'b0}});
    assign head_instr_s = mem_r[rd_ptr_r][31:0];
    assign head_pc_s    = mem_r[rd_ptr_r][63:32];

    // Next FIFO occupancy from the push/pop pair
    always_comb begin
        cnt_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = count_r + CNT_ONE;
            2'b01:   cnt_nxt_s = count_r - CNT_ONE;
            default: cnt_nxt_s = count_r;
        endcase
    end

    // FIFO pointers, occupancy and registered ready; flush overrides everything
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
            in_ready_r <= 1'b1;
        end else if (flush) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r    <= cnt_nxt_s;
            in_ready_r <= (cnt_nxt_s < CNT_FULL);
        end
    end

    // FIFO data array; contents are don't-care while unoccupied, so no reset
    always_ff @(posedge clock) begin
        if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= {inPc, inInstr};
        end
    end

    // RV32I field decode of the FIFO head
    always_comb begin
        dec_sub_s     = 3'b111;
        dec_flag_s    = 1'b0;
        dec_imm_s     = 32'h0000_0000;
        dec_rs1_s     = 5'd0;
        dec_rs2_s     = 5'd0;
        dec_rd_s      = 5'd0;
        dec_use_rs1_s = 1'b0;
        dec_use_rs2_s = 1'b0;
        dec_use_rd_s  = 1'b0;
        dec_illegal_s = 1'b0;
        dec_muldiv_s  = 1'b0;
        // Every legal opcode ends in 2'b11, so compressed/garbage words fall into default.
        case (head_instr_s[6:0])
            OPC_LUI: begin
                dec_rd_s     = head_instr_s[11:7];
                dec_use_rd_s = 1'b1;
                dec_imm_s    = {head_instr_s[31:12], 12'h000};
            end
            OPC_AUIPC: begin
                dec_rd_s     = head_instr_s[11:7];
                dec_use_rd_s = 1'b1;
                dec_imm_s    = {head_instr_s[31:12], 12'h000} + head_pc_s;
            end
            OPC_JAL: begin
                dec_rd_s     = head_instr_s[11:7];
                dec_use_rd_s = 1'b1;
                dec_imm_s    = {{11{head_instr_s[31]}}, head_instr_s[31], head_instr_s[19:12],
                                head_instr_s[20], head_instr_s[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD: begin
                dec_rd_s      = head_instr_s[11:7];
                dec_rs1_s     = head_instr_s[19:15];
                dec_use_rd_s  = 1'b1;
                dec_use_rs1_s = 1'b1;
                dec_sub_s     = head_instr_s[14:12];
                dec_imm_s     = {{20{head_instr_s[31]}}, head_instr_s[31:20]};
            end
            OPC_BRANCH: begin
                dec_rs1_s     = head_instr_s[19:15];
                dec_rs2_s     = head_instr_s[24:20];
                dec_use_rs1_s = 1'b1;
                dec_use_rs2_s = 1'b1;
                dec_sub_s     = head_instr_s[14:12];
                dec_imm_s     = {{19{head_instr_s[31]}}, head_instr_s[31], head_instr_s[7],
                                 head_instr_s[30:25], head_instr_s[11:8], 1'b0};
            end
            OPC_STORE: begin
                dec_rs1_s     = head_instr_s[19:15];
                dec_rs2_s     = head_instr_s[24:20];
                dec_use_rs1_s = 1'b1;
                dec_use_rs2_s = 1'b1;
                dec_sub_s     = head_instr_s[14:12];
                dec_imm_s     = {{20{head_instr_s[31]}}, head_instr_s[31:25], head_instr_s[11:7]};
            end
            OPC_OPIMM: begin
                dec_rd_s      = head_instr_s[11:7];
                dec_rs1_s     = head_instr_s[19:15];
                dec_use_rd_s  = 1'b1;
                dec_use_rs1_s = 1'b1;
                dec_sub_s     = head_instr_s[14:12];
                // Shift-immediates carry shamt in [24:20] and the arith/logic select in bit 30.
                if ((head_instr_s[14:12] == 3'b001) || (head_instr_s[14:12] == 3'b101)) begin
                    dec_imm_s  = {27'h000_0000, head_instr_s[24:20]};
                    dec_flag_s = head_instr_s[30];
                end else begin
                    dec_imm_s  = {{20{head_instr_s[31]}}, head_instr_s[31:20]};
                    dec_flag_s = 1'b0;
                end
            end
            OPC_OP: begin
                if (head_instr_s[31:25] == 7'b0000001) begin
`ifdef DECODE_MULDIV_EN
                    dec_rd_s      = head_instr_s[11:7];
                    dec_rs1_s     = head_instr_s[19:15];
                    dec_rs2_s     = head_instr_s[24:20];
                    dec_use_rd_s  = 1'b1;
                    dec_use_rs1_s = 1'b1;
                    dec_use_rs2_s = 1'b1;
                    dec_sub_s     = head_instr_s[14:12];
                    dec_muldiv_s  = 1'b1;
`else
                    dec_illegal_s = 1'b1;
`endif
                end else begin
                    dec_rd_s      = head_instr_s[11:7];
                    dec_rs1_s     = head_instr_s[19:15];
                    dec_rs2_s     = head_instr_s[24:20];
                    dec_use_rd_s  = 1'b1;
                    dec_use_rs1_s = 1'b1;
                    dec_use_rs2_s = 1'b1;
                    dec_sub_s     = head_instr_s[14:12];
                    dec_flag_s    = head_instr_s[30];
                end
            end
            OPC_FENCE: begin
                dec_sub_s = head_instr_s[14:12];
                dec_imm_s = {24'h00_0000, head_instr_s[27:20]};
            end
            default: begin
                // Still issued so the ROB can raise the trap in order.
                dec_illegal_s = 1'b1;
            end
        endcase
    end

    // Output micro-op register: load on pop, drop valid after an unrefilled handshake, else hold
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r     <= 1'b0;
            out_op_r        <= 7'd0;
            out_sub_r       <= 3'd0;
            out_flag_r      <= 1'b0;
            out_imm_r       <= 32'h0000_0000;
            out_pc_r        <= 32'h0000_0000;
            out_rs1_r       <= 5'd0;
            out_rs2_r       <= 5'd0;
            out_rd_r        <= 5'd0;
            out_use_rs1_r   <= 1'b0;
            out_use_rs2_r   <= 1'b0;
            out_writes_rd_r <= 1'b0;
            out_illegal_r   <= 1'b0;
            out_muldiv_r    <= 1'b0;
        end else if (flush) begin
            out_valid_r     <= 1'b0;
        end else if (pop_s) begin
            out_valid_r     <= 1'b1;
            out_op_r        <= head_instr_s[6:0];
            out_sub_r       <= dec_sub_s;
            out_flag_r      <= dec_flag_s;
            out_imm_r       <= dec_imm_s;
            out_pc_r        <= head_pc_s;
            out_rs1_r       <= dec_rs1_s;
            out_rs2_r       <= dec_rs2_s;
            out_rd_r        <= dec_rd_s;
            out_use_rs1_r   <= dec_use_rs1_s;
            out_use_rs2_r   <= dec_use_rs2_s;
            out_writes_rd_r <= dec_use_rd_s && (dec_rd_s != 5'd0);
            out_illegal_r   <= dec_illegal_s;
            out_muldiv_r    <= dec_muldiv_s;
        end else if (out_valid_r && outReady) begin
            out_valid_r     <= 1'b0;
        end else begin
            out_valid_r     <= out_valid_r;
        end
    end

    assign inReady     = in_ready_r;
    assign count       = count_r;
    assign outValid    = out_valid_r;
    assign outOpType   = out_op_r;
    assign outSubType  = out_sub_r;
    assign outFlag     = out_flag_r;
    assign outImm      = out_imm_r;
    assign outPc       = out_pc_r;
    assign outRs1      = out_rs1_r;
    assign outRs2      = out_rs2_r;
    assign outRd       = out_rd_r;
    assign outUseRs1   = out_use_rs1_r;
    assign outUseRs2   = out_use_rs2_r;
    assign outWritesRd = out_writes_rd_r;
    assign outIllegal  = out_illegal_r;
    assign outMulDiv   = out_muldiv_r;

endmodule

// File: tb/tb_instr_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_decode_queue
//   Directed self-checking bench for instr_decode_queue (DEPTH=4). Inputs are
//   driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_instr_decode_queue;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [31:0] inInstr;
    logic [31:0] inPc;
    logic        outValid;
    logic        outReady;
    logic [6:0]  outOpType;
    logic [2:0]  outSubType;
    logic        outFlag;
    logic [31:0] outImm;
    logic [31:0] outPc;
    logic [4:0]  outRs1;
    logic [4:0]  outRs2;
    logic [4:0]  outRd;
    logic        outUseRs1;
    logic        outUseRs2;
    logic        outWritesRd;
    logic        outIllegal;
    logic        outMulDiv;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    instr_decode_queue #(.DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .inValid(inValid), .inReady(inReady), .inInstr(inInstr), .inPc(inPc),
        .outValid(outValid), .outReady(outReady),
        .outOpType(outOpType), .outSubType(outSubType), .outFlag(outFlag),
        .outImm(outImm), .outPc(outPc), .outRs1(outRs1), .outRs2(outRs2), .outRd(outRd),
        .outUseRs1(outUseRs1), .outUseRs2(outUseRs2), .outWritesRd(outWritesRd),
        .outIllegal(outIllegal), .outMulDiv(outMulDiv), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // addi xk, x0, k
    function automatic logic [31:0] addi_enc(input logic [4:0] k);
        return {7'b0000000, k, 5'd0, 3'b000, k, 7'b0010011};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        inInstr = 32'h0; inPc = 32'h0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Single push, then wait for the decoded op (outReady held high)
    task automatic push_and_wait(input logic [31:0] instr, input logic [31:0] pc);
        outReady = 1'b1;
        inValid = 1'b1; inInstr = instr; inPc = pc;
        @(negedge clock);
        inValid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL reset_outValid got=%0b exp=0", outValid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL reset_inReady got=%0b exp=1", inReady); end
        total++; if (outImm !== 32'h0 || outOpType !== 7'h0) begin bad++;
            $display("FAIL reset_fields imm=%h op=%h exp=0", outImm, outOpType); end
    endtask

    task automatic test_addi();
        do_reset();
        outReady = 1'b1;
        inValid = 1'b1; inInstr = 32'h00500093; inPc = 32'h0000_0040;
        @(negedge clock);
        inValid = 1'b0;
        total++; if (count !== 3'd1 || outValid !== 1'b0) begin bad++;
            $display("FAIL addi_latency count=%0d outValid=%0b exp 1/0", count, outValid); end
        @(negedge clock);
        total++; if (outValid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0b exp=1", outValid); end
        total++; if (outOpType !== 7'b0010011 || outRd !== 5'd1 || outImm !== 32'd5) begin bad++;
            $display("FAIL addi_fields op=%b rd=%0d imm=%h exp 0010011/1/5", outOpType, outRd, outImm); end
        total++; if (outUseRs1 !== 1'b1 || outWritesRd !== 1'b1 || outUseRs2 !== 1'b0 || outSubType !== 3'b000) begin bad++;
            $display("FAIL addi_flags u1=%0b wr=%0b u2=%0b sub=%b exp 1/1/0/000", outUseRs1, outWritesRd, outUseRs2, outSubType); end
        total++; if (outPc !== 32'h40 || count !== 3'd0) begin bad++;
            $display("FAIL addi_pc pc=%h count=%0d exp 40/0", outPc, count); end
        @(negedge clock);
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL addi_drop got=%0b exp=0", outValid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held_pc;
        do_reset();
        outReady = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            total++; if (inReady !== 1'b1) begin bad++; $display("FAIL bp_ready_%0d got=0 exp=1", k); end
            inValid = 1'b1; inInstr = addi_enc(5'(k)); inPc = 32'h1000 + 32'(k * 4);
            @(negedge clock);
        end
        // Offer a sixth op while full; it must be refused.
        inInstr = addi_enc(5'd6); inPc = 32'h2000;
        total++; if (count !== 3'd4 || inReady !== 1'b0) begin bad++;
            $display("FAIL bp_full count=%0d inReady=%0b exp 4/0", count, inReady); end
        total++; if (outValid !== 1'b1 || outRd !== 5'd1 || outImm !== 32'd1) begin bad++;
            $display("FAIL bp_head valid=%0b rd=%0d imm=%h exp 1/1/1", outValid, outRd, outImm); end
        held_pc = outPc;
        @(negedge clock);
        inValid = 1'b0;
        total++; if (count !== 3'd4 || outRd !== 5'd1 || outPc !== held_pc || outValid !== 1'b1) begin bad++;
            $display("FAIL bp_hold count=%0d rd=%0d pc=%h exp 4/1/%h", count, outRd, outPc, held_pc); end
        outReady = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clock);
            total++; if (outValid !== 1'b1 || outRd !== 5'(k) || outPc !== 32'h1000 + 32'(k * 4) || count !== 3'(5 - k)) begin bad++;
                $display("FAIL bp_drain_%0d valid=%0b rd=%0d pc=%h count=%0d", k, outValid, outRd, outPc, count); end
        end
        @(negedge clock);
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL bp_extra got valid rd=%0d exp none", outRd); end
    endtask

    task automatic test_branch_auipc();
        do_reset();
        push_and_wait(32'hFE000EE3, 32'h0000_0100);
        total++; if (outValid !== 1'b1 || outSubType !== 3'b000 || outImm !== 32'hFFFF_FFFC) begin bad++;
            $display("FAIL beq_imm valid=%0b sub=%b imm=%h exp 1/000/fffffffc", outValid, outSubType, outImm); end
        total++; if (outUseRs1 !== 1'b1 || outUseRs2 !== 1'b1 || outWritesRd !== 1'b0 || outIllegal !== 1'b0) begin bad++;
            $display("FAIL beq_flags u1=%0b u2=%0b wr=%0b ill=%0b exp 1/1/0/0", outUseRs1, outUseRs2, outWritesRd, outIllegal); end
        push_and_wait(32'h00001097, 32'h0000_0100);
        total++; if (outImm !== 32'h0000_1100 || outRd !== 5'd1 || outWritesRd !== 1'b1) begin bad++;
            $display("FAIL auipc imm=%h rd=%0d wr=%0b exp 1100/1/1", outImm, outRd, outWritesRd); end
        total++; if (outSubType !== 3'b111 || outUseRs1 !== 1'b0 || outOpType !== 7'b0010111) begin bad++;
            $display("FAIL auipc_fields sub=%b u1=%0b op=%b exp 111/0/0010111", outSubType, outUseRs1, outOpType); end
    endtask

    task automatic test_flush();
        do_reset();
        outReady = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            inValid = 1'b1; inInstr = addi_enc(5'(k)); inPc = 32'(k);
            @(negedge clock);
        end
        total++; if (count !== 3'd3 || outValid !== 1'b1) begin bad++;
            $display("FAIL flush_pre count=%0d valid=%0b exp 3/1", count, outValid); end
        flush = 1'b1; inValid = 1'b1; inInstr = addi_enc(5'd9);
        @(negedge clock);
        flush = 1'b0; inValid = 1'b0;
        total++; if (count !== 3'd0 || outValid !== 1'b0 || inReady !== 1'b1) begin bad++;
            $display("FAIL flush_post count=%0d valid=%0b ready=%0b exp 0/0/1", count, outValid, inReady); end
        outReady = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            total++; if (outValid !== 1'b0 || count !== 3'd0) begin bad++;
                $display("FAIL flush_dropped_%0d valid=%0b rd=%0d count=%0d exp 0", k, outValid, outRd, count); end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        push_and_wait(32'h02208133, 32'h0000_0200);
`ifdef DECODE_MULDIV_EN
        total++; if (outMulDiv !== 1'b1 || outIllegal !== 1'b0 || outRd !== 5'd2 || outSubType !== 3'b000) begin bad++;
            $display("FAIL mul_decode md=%0b ill=%0b rd=%0d sub=%b exp 1/0/2/000", outMulDiv, outIllegal, outRd, outSubType); end
`else
        total++; if (outMulDiv !== 1'b0 || outIllegal !== 1'b1 || outValid !== 1'b1) begin bad++;
            $display("FAIL mul_decode md=%0b ill=%0b valid=%0b exp 0/1/1", outMulDiv, outIllegal, outValid); end
`endif
        push_and_wait(32'hFFFF_FFFF, 32'h0000_0204);
        total++; if (outIllegal !== 1'b1 || outMulDiv !== 1'b0 || outValid !== 1'b1 || outOpType !== 7'h7F) begin bad++;
            $display("FAIL ffff_illegal ill=%0b md=%0b valid=%0b op=%h exp 1/0/1/7f", outIllegal, outMulDiv, outValid, outOpType); end
        total++; if (outImm !== 32'h0 || outUseRs1 !== 1'b0 || outUseRs2 !== 1'b0 || outWritesRd !== 1'b0) begin bad++;
            $display("FAIL ffff_fields imm=%h u1=%0b u2=%0b wr=%0b exp 0", outImm, outUseRs1, outUseRs2, outWritesRd); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        outReady = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            inValid = 1'b1; inInstr = addi_enc(5'(k)); inPc = 32'(k);
            @(negedge clock);
        end
        inValid = 1'b0;
        reset_n = 1'b0;
        #2;
        total++; if (count !== 3'd0 || outValid !== 1'b0 || inReady !== 1'b1) begin bad++;
            $display("FAIL midreset count=%0d valid=%0b ready=%0b exp 0/0/1", count, outValid, inReady); end
        @(negedge clock);
        reset_n = 1'b1; outReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            total++; if (outValid !== 1'b0) begin bad++;
                $display("FAIL midreset_emit_%0d got valid rd=%0d exp none", k, outRd); end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_backpressure();
        test_branch_auipc();
        test_flush();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
